// File: rtl/g256_inv_iter.sv
// Iterative GF(2^8) inverter for the tower-field AES S-box, normal bases (Y^16,Y)/(Z^4,Z)/(W^2,W).
// Byte -> nibbles A,B; one GF(2^4) inversion plus three GF(2^4) products, one byte in flight.

module g16_mul (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] z
);
  function automatic logic [1:0] g4_mul(input logic [1:0] u, input logic [1:0] v);
    logic t;
    t = (u[1] ^ u[0]) & (v[1] ^ v[0]);
    return {(u[1] & v[1]) ^ t, (u[0] & v[0]) ^ t};
  endfunction

  logic [1:0] k, kn;
  assign k  = g4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]);
  assign kn = {k[0], k[1] ^ k[0]};  // scale by N = W^2
  assign z  = {g4_mul(x[3:2], y[3:2]) ^ kn, g4_mul(x[1:0], y[1:0]) ^ kn};
endmodule

module g16_sq_scl (
  input  logic [3:0] x,
  output logic [3:0] z
);
  // linear map: hi = (a^b)^2, lo = N^2 * b^2
  assign z = {x[2] ^ x[0], x[3] ^ x[1], x[0] ^ x[1], x[0]};
endmodule

module g16_inv (
  input  logic [3:0] x,
  output logic [3:0] z
);
  function automatic logic [1:0] g4_mul(input logic [1:0] u, input logic [1:0] v);
    logic t;
    t = (u[1] ^ u[0]) & (v[1] ^ v[0]);
    return {(u[1] & v[1]) ^ t, (u[0] & v[0]) ^ t};
  endfunction

  logic [1:0] a, b, c, cd, e;
  assign a  = x[3:2];
  assign b  = x[1:0];
  assign c  = {a[1] ^ b[1], a[0] ^ b[0] ^ a[1] ^ b[1]};  // N * (a^b)^2
  assign cd = c ^ g4_mul(a, b);
  assign e  = {cd[0], cd[1]};                           // GF(4) inverse is squaring
  assign z  = {g4_mul(e, b), g4_mul(e, a)};
endmodule

module g256_inv_iter #(
  parameter int SHARE_MUL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, MUL_D, INV, MUL_HI, MUL_LO, DONE} state_t;

  state_t     state;
  logic [3:0] a_q, b_q, c_q, d_q, f_q;
  logic [3:0] c_w, d_w, f_w, hi_w, lo_w;

  g16_sq_scl u_sq (.x(a_q ^ b_q), .z(c_w));
  g16_inv    u_inv (.x(c_q ^ d_q), .z(f_w));

  if (SHARE_MUL != 0) begin : g_shared
    logic [3:0] mx, my, mz;
    // operands default to (A,B) so the multiplier input is defined every cycle
    always_comb begin
      mx = a_q;
      my = b_q;
      if (state == MUL_HI) begin
        mx = f_q;
        my = b_q;
      end else if (state == MUL_LO) begin
        mx = f_q;
        my = a_q;
      end
    end
    g16_mul u_mul (.x(mx), .y(my), .z(mz));
    assign d_w  = mz;
    assign hi_w = mz;
    assign lo_w = mz;
  end else begin : g_par
    g16_mul u_mul_d  (.x(a_q), .y(b_q), .z(d_w));
    g16_mul u_mul_hi (.x(f_q), .y(b_q), .z(hi_w));
    g16_mul u_mul_lo (.x(f_q), .y(a_q), .z(lo_w));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      f_q       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= in_data[7:4];
          b_q      <= in_data[3:0];
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= MUL_D;
        end
        MUL_D: begin
          d_q   <= d_w;
          c_q   <= c_w;
          state <= INV;
        end
        INV: begin
          f_q   <= f_w;
          state <= MUL_HI;
        end
        MUL_HI: begin
          out_data[7:4] <= hi_w;
          if (SHARE_MUL != 0) begin
            state <= MUL_LO;
          end else begin
            out_data[3:0] <= lo_w;
            out_valid     <= 1'b1;
            state         <= DONE;
          end
        end
        MUL_LO: begin
          out_data[3:0] <= lo_w;
          out_valid     <= 1'b1;
          state         <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_g256_inv_iter.sv
// Bench for g256_inv_iter: shared (u0) and parallel (u1) multiplier builds checked against
// a reference inverse found by searching for y with x*y == one in the normal-basis field.

module tb_g256_inv_iter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in_valid = '0, in_ready, out_valid, out_ready = '0, busy;
  logic [7:0] in_data [2];
  logic [7:0] out_data [2];

  int checks = 0, errors = 0;
  int cyc = 0;
  int acc_t [2][512];
  int acc_n [2] = '{0, 0};
  logic [7:0] out_v [2][512];
  int out_n [2] = '{0, 0};
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  g256_inv_iter #(.SHARE_MUL(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));
  g256_inv_iter #(.SHARE_MUL(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  // record accept cycles and delivered results
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int s = 0; s < 2; s++) begin
      if (!rst && in_valid[s] && in_ready[s]) begin
        acc_t[s][acc_n[s]] <= cyc;
        acc_n[s] <= acc_n[s] + 1;
      end
      if (!rst && out_valid[s] && out_ready[s]) begin
        out_v[s][out_n[s]] <= out_data[s];
        out_n[s] <= out_n[s] + 1;
      end
    end
  end

  // GF(4), element x1*W^2 + x0*W with W^3 = 1 and W^2 + W + 1 = 0
  function automatic logic [1:0] r4_mul(input logic [1:0] x, input logic [1:0] y);
    logic hi, lo;
    hi = (x[0] & y[0]) ^ (x[1] & y[0]) ^ (x[0] & y[1]);
    lo = (x[1] & y[1]) ^ (x[1] & y[0]) ^ (x[0] & y[1]);
    return {hi, lo};
  endfunction

  // (aZ^4 + bZ)(cZ^4 + dZ) with Z^2 + Z + nu = 0, nu = W^2
  function automatic logic [3:0] r16_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] ac, bd, cr, t;
    ac = r4_mul(x[3:2], y[3:2]);
    bd = r4_mul(x[1:0], y[1:0]);
    cr = r4_mul(x[3:2], y[1:0]) ^ r4_mul(x[1:0], y[3:2]);
    t  = r4_mul(2'b10, ac ^ bd ^ cr);
    return {ac ^ t, bd ^ t};
  endfunction

  // (aY^16 + bY)(cY^16 + dY) with Y^2 + Y + nu = 0, nu = W*Z
  function automatic logic [7:0] r256_mul(input logic [7:0] x, input logic [7:0] y);
    logic [3:0] ac, bd, cr, t;
    ac = r16_mul(x[7:4], y[7:4]);
    bd = r16_mul(x[3:0], y[3:0]);
    cr = r16_mul(x[7:4], y[3:0]) ^ r16_mul(x[3:0], y[7:4]);
    t  = r16_mul(4'h1, ac ^ bd ^ cr);
    return {ac ^ t, bd ^ t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one transfer with out_ready held; lat counts edges from the accept edge (inclusive) to out_valid
  task automatic xfer(input int s, input logic [7:0] x, output logic [7:0] y, output int lat,
                      output bit busy_ok);
    int guard;
    guard = 0;
    busy_ok = 1'b1;
    out_ready[s] = 1'b1;
    while (!in_ready[s] && guard < 50) begin @(negedge clk); guard++; end
    chk("xfer in_ready wait", guard < 50, 1);
    in_data[s] = x;
    in_valid[s] = 1'b1;
    @(posedge clk);
    #1 in_valid[s] = 1'b0;
    lat = 1;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!busy[s]) busy_ok = 1'b0;
    end while (!out_valid[s] && lat < 40);
    y = out_data[s];
  endtask

  task automatic stream(input int s, output int b_out, output int b_acc);
    int guard;
    b_out = out_n[s];
    b_acc = acc_n[s];
    out_ready[s] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data[s] = 8'(i);
      in_valid[s] = 1'b1;
      guard = 0;
      while (!in_ready[s] && guard < 50) begin @(negedge clk); guard++; end
      chk("stream accept wait", guard < 50, 1);
      @(posedge clk);
      #1;
    end
    in_valid[s] = 1'b0;
    guard = 0;
    while (out_n[s] < b_out + 256 && guard < 100) begin @(negedge clk); guard++; end
    chk("stream drain", out_n[s] - b_out, 256);
  endtask

  initial begin
    logic [7:0] y, y0, x;
    int lat, bo0, ba0, bo1, ba1, sp;
    bit bok;

    inv_tab[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      inv_tab[a] = 8'h00;
      for (int b = 1; b < 256; b++)
        if (r256_mul(8'(a), 8'(b)) == 8'hFF) inv_tab[a] = 8'(b);
    end

    // reset with a byte offered at the same time: the byte is dropped
    in_data[0] = 8'h37; in_data[1] = 8'h37;
    in_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 2'b00;
    for (int s = 0; s < 2; s++) begin
      chk("reset out_valid", out_valid[s], 0);
      chk("reset out_data", out_data[s], 0);
      chk("reset busy", busy[s], 0);
      chk("reset in_ready", in_ready[s], 1);
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst+valid dropped busy", busy[s], 0);
      chk("rst+valid dropped out", out_n[s], 0);
    end

    // zero input, latency and busy on both builds
    for (int s = 0; s < 2; s++) begin
      xfer(s, 8'h00, y, lat, bok);
      chk("zero data", y, 8'h00);
      chk("zero latency", lat, (s == 0) ? 5 : 4);
      chk("zero busy", bok, 1);
    end

    // one maps to one, twice
    xfer(0, 8'hFF, y, lat, bok);
    chk("one data", y, 8'hFF);
    xfer(0, y, y, lat, bok);
    chk("one again", y, 8'hFF);

    // random transfers on both builds
    for (int k = 0; k < 8; k++) begin
      x = 8'($urandom);
      xfer(k % 2, x, y, lat, bok);
      chk("random data", y, inv_tab[x]);
    end

    // exhaustive back-to-back on both builds
    @(negedge clk);
    stream(0, bo0, ba0);
    stream(1, bo1, ba1);
    for (int i = 0; i < 256; i++) begin
      chk("exh golden", out_v[0][bo0 + i], inv_tab[i]);
      if (i != 0) chk("exh x*inv", r256_mul(8'(i), out_v[0][bo0 + i]), 8'hFF);
      chk("exh inv(inv)", out_v[0][bo0 + 32'(out_v[0][bo0 + i])], i);
      chk("exh par vs shared", out_v[1][bo1 + i], out_v[0][bo0 + i]);
    end
    for (int i = 1; i < 256; i++) begin
      sp = acc_t[0][ba0 + i] - acc_t[0][ba0 + i - 1];
      chk("spacing shared", sp, 6);
      sp = acc_t[1][ba1 + i] - acc_t[1][ba1 + i - 1];
      chk("spacing par", sp, 5);
    end

    // backpressure: result held, extra inputs ignored
    x = 8'($urandom_range(1, 255));
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_data[0] = x;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_data[0] = ~x;
    lat = 0;
    while (!out_valid[0] && lat < 40) begin @(negedge clk); lat++; end
    chk("bp reached done", out_valid[0], 1);
    y0 = out_data[0];
    chk("bp data", y0, inv_tab[x]);
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = k[0];
      @(negedge clk);
      chk("bp out_valid hold", out_valid[0], 1);
      chk("bp out_data hold", out_data[0], y0);
      chk("bp in_ready low", in_ready[0], 0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    @(negedge clk);
    chk("bp release out_valid", out_valid[0], 0);
    chk("bp release in_ready", in_ready[0], 1);
    chk("bp release busy", busy[0], 0);
    chk("bp release out_data", out_data[0], y0);
    x = 8'($urandom);
    xfer(0, x, y, lat, bok);
    chk("bp next byte", y, inv_tab[x]);

    // reset while computing 0x53, during the high-nibble multiply
    @(negedge clk);
    while (!in_ready[0]) @(negedge clk);
    in_data[0] = 8'h53;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort out_valid", out_valid[0], 0);
    chk("abort busy", busy[0], 0);
    chk("abort in_ready", in_ready[0], 1);
    chk("abort out_data", out_data[0], 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort no stale", out_valid[0], 0);
    end
    xfer(0, 8'hFF, y, lat, bok);
    chk("abort then one", y, 8'hFF);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
